key_expansion_seq: RTL and testbench

- Iterative AES key schedule. It expands a 128/192/256-bit cipher key into the full round-key bus consumed by the Cipher datapath (words[0:128*(11+2*x)-1]).
- Produces one 32-bit schedule word per clock and raises done when the whole bus is valid.
- done drives the Cipher's enable.
- Sits directly upstream of Cipher and shares its key-size parameter x.

---
 rtl/key_expansion_seq_if.sv | 17 +
 rtl/key_expansion_seq.sv | 160 ++++++++++++++++
 tb/tb_key_expansion_seq.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_expansion_seq_if.sv
// Key-expansion bus: cipher key and start request in, status and the round-key bus out.
// Bit 0 of key and words is the MSB of the first byte, so both vectors are ascending.
interface key_expansion_seq_if #(
    parameter int unsigned x = 0
);
    localparam int unsigned KEY_W   = 128 + 64 * x;
    localparam int unsigned WORDS_W = 128 * (11 + 2 * x);

    logic [0:KEY_W-1]   key;
    logic               start;
    logic               busy;
    logic               done;
    logic [0:WORDS_W-1] words;

    modport master (output key, start, input busy, done, words);
    modport slave  (input key, start, output busy, done, words);
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per clock, done when the bus is complete.
// Optional build macro KEYEXP_START_ABORT_EN: a start during expansion restarts the run with the new key.
module key_expansion_seq #(
    parameter int unsigned x = 0
) (
    input  logic               clk,
    input  logic               rst,
    key_expansion_seq_if.slave bus
);
    localparam int unsigned NK      = 4 + 2 * x;
    localparam int unsigned NR      = 10 + 2 * x;
    localparam int unsigned NW      = 4 * (NR + 1);
    localparam int unsigned WORDS_W = 32 * NW;
    localparam int unsigned CW      = 6;
    localparam int unsigned MW      = 3;

    // AES forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8 * (255 - 32'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     w_q [NW];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   mod_q, mod_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_key;
    logic            wr_word;
    logic            restart;
    logic [31:0]     prev_w, back_w, sub_in, sub_out, temp_w, new_w;
    logic [0:WORDS_W-1] words_c;

`ifdef KEYEXP_START_ABORT_EN
    assign restart = bus.start;
`else
    assign restart = bus.start && (state_q != S_EXPAND);
`endif

    // Next schedule word from w[i-1] and w[i-Nk]; one shared SubWord for both substitution cases
    always_comb begin
        prev_w  = w_q[cnt_q - CW'(1)];
        back_w  = w_q[cnt_q - CW'(NK)];
        sub_in  = (mod_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        if (mod_q == '0) begin
            temp_w = sub_out ^ {rcon_q, 24'h000000};
        end else if ((NK == 8) && (mod_q == MW'(4))) begin
            temp_w = sub_out;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    // Next-state, counter and status logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mod_d    = mod_q;
        rcon_d   = rcon_q;
        busy_d   = busy_q;
        done_d   = done_q;
        load_key = 1'b0;
        wr_word  = 1'b0;
        if (restart) begin
            load_key = 1'b1;
            cnt_d    = CW'(NK);
            mod_d    = '0;
            rcon_d   = 8'h01;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            state_d  = S_EXPAND;
        end else if (state_q == S_EXPAND) begin
            wr_word = 1'b1;
            if (cnt_q == CW'(NW - 1)) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + CW'(1);
                mod_d = (mod_q == MW'(NK - 1)) ? '0 : mod_q + MW'(1);
                if (mod_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            mod_q  <= '0;
            rcon_q <= 8'h01;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mod_q  <= mod_d;
            rcon_q <= rcon_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Schedule storage: key words on a start, one computed word per expansion cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (load_key) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= bus.key[32*k +: 32];
            end
        end else if (wr_word) begin
            w_q[cnt_q] <= new_w;
        end
    end

    // Flatten stored words onto the round-key bus
    always_comb begin
        words_c = '0;
        for (int k = 0; k < NW; k++) begin
            words_c[32*k +: 32] = w_q[k];
        end
    end

    assign bus.words = words_c;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: all three key sizes against a behavioural key-schedule model.
module tb_key_expansion_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0]  sbox_tab [256];
    logic [31:0] ref_w [60];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    key_expansion_seq_if #(.x(0)) if0 ();
    key_expansion_seq_if #(.x(1)) if1 ();
    key_expansion_seq_if #(.x(2)) if2 ();

    key_expansion_seq #(.x(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    key_expansion_seq #(.x(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    key_expansion_seq #(.x(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map
    task automatic build_sbox();
        logic [7:0] p;
        for (int a = 0; a < 256; a++) begin
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(a));
            sbox_tab[a] = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    // Reference schedule; key is left-aligned, first key word in bits [255:224]
    task automatic ref_sched(input int xs, input logic [255:0] k);
        int nk;
        int nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * xs;
        nw = 4 * (11 + 2 * xs);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [31:0] dut_word(input int xs, input int i);
        case (xs)
            0:       return if0.words[32*i +: 32];
            1:       return if1.words[32*i +: 32];
            default: return if2.words[32*i +: 32];
        endcase
    endfunction

    function automatic logic dut_busy(input int xs);
        case (xs)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic dut_done(input int xs);
        case (xs)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic dut_zero(input int xs);
        case (xs)
            0:       return if0.words == '0;
            1:       return if1.words == '0;
            default: return if2.words == '0;
        endcase
    endfunction

    // First schedule word index where the DUT differs from ref_w, or -1
    function automatic int sched_bad(input int xs);
        int nw;
        nw = 4 * (11 + 2 * xs);
        for (int i = 0; i < nw; i++) if (dut_word(xs, i) !== ref_w[i]) return i;
        return -1;
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input int xs, input logic [255:0] k, input logic s);
        case (xs)
            0:       begin if0.key = k[255 -: 128]; if0.start = s; end
            1:       begin if1.key = k[255 -: 192]; if1.start = s; end
            default: begin if2.key = k;             if2.start = s; end
        endcase
    endtask

    // One-cycle start pulse; returns #1 after the start edge
    task automatic start_run(input int xs, input logic [255:0] k);
        @(negedge clk);
        drive(xs, k, 1'b1);
        @(posedge clk);
        #1;
        drive(xs, k, 1'b0);
    endtask

    // n = edge number (start edge is 1) after which done was first seen high, capped at 200
    task automatic run_to_done(input int xs, input logic [255:0] k, output int n);
        start_run(xs, k);
        n = 1;
        while (dut_done(xs) !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        for (int xs = 0; xs < 3; xs++) begin
            n_checks++;
            if (dut_busy(xs) !== 1'b0 || dut_done(xs) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags x=%0d: busy/done %b/%b, expected 0/0", xs, dut_busy(xs), dut_done(xs));
            end
            n_checks++;
            if (dut_zero(xs) !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_words x=%0d: words nonzero, expected all zero", xs);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_known_vectors();
        logic [255:0] keys [3];
        int          lat  [3] = '{41, 47, 53};
        int          lo_i [3] = '{4, 6, 8};
        int          hi_i [3] = '{43, 51, 59};
        logic [31:0] lo_v [3] = '{32'ha0fafe17, 32'hfe0c91f7, 32'h9ba35411};
        logic [31:0] hi_v [3] = '{32'hb6630ca6, 32'h01002202, 32'h706c631e};
        int n, bad;
        keys[0] = KEY128; keys[1] = KEY192; keys[2] = KEY256;
        for (int xs = 0; xs < 3; xs++) begin
            run_to_done(xs, keys[xs], n);
            n_checks++;
            if (n != lat[xs]) begin
                n_fail++;
                $display("FAIL known_latency x=%0d: done after %0d cycles, expected %0d", xs, n, lat[xs]);
            end
            n_checks++;
            if (dut_busy(xs) !== 1'b0) begin
                n_fail++;
                $display("FAIL known_busy x=%0d: busy %b at done, expected 0", xs, dut_busy(xs));
            end
            n_checks++;
            if (dut_word(xs, lo_i[xs]) !== lo_v[xs]) begin
                n_fail++;
                $display("FAIL known_first x=%0d: w[%0d]=%h, expected %h", xs, lo_i[xs], dut_word(xs, lo_i[xs]), lo_v[xs]);
            end
            n_checks++;
            if (dut_word(xs, hi_i[xs]) !== hi_v[xs]) begin
                n_fail++;
                $display("FAIL known_last x=%0d: w[%0d]=%h, expected %h", xs, hi_i[xs], dut_word(xs, hi_i[xs]), hi_v[xs]);
            end
            ref_sched(xs, keys[xs]);
            bad = sched_bad(xs);
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL known_sched x=%0d: w[%0d]=%h, expected %h", xs, bad, dut_word(xs, bad), ref_w[bad]);
            end
        end
    endtask

    task automatic test_random_keys();
        logic [255:0] k;
        int n, bad;
        for (int r = 0; r < 12; r++) begin
            for (int xs = 0; xs < 3; xs++) begin
                k = rand_key();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_to_done(xs, k, n);
                n_checks++;
                if (n != 41 + 6 * xs) begin
                    n_fail++;
                    $display("FAIL random_latency x=%0d: done after %0d cycles, expected %0d", xs, n, 41 + 6 * xs);
                end
                ref_sched(xs, k);
                bad = sched_bad(xs);
                n_checks++;
                if (bad >= 0) begin
                    n_fail++;
                    $display("FAIL random_sched x=%0d key=%h: w[%0d]=%h, expected %h", xs, k, bad, dut_word(xs, bad), ref_w[bad]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [255:0] k1, k2;
        int t, m, bad;
        k1 = rand_key();
        k2 = rand_key();
        start_run(0, k1);
        t = 1;
        repeat (9) begin @(posedge clk); #1; t++; end
        @(negedge clk);
        drive(0, k2, 1'b1);
        @(posedge clk);
        #1;
        drive(0, k2, 1'b0);
        t++;
        m = 1;
        n_checks++;
        if (dut_busy(0) !== 1'b1 || dut_done(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_flags: busy/done %b/%b, expected 1/0", dut_busy(0), dut_done(0));
        end
        while (dut_done(0) !== 1'b1 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
            m++;
        end
`ifdef KEYEXP_START_ABORT_EN
        n_checks++;
        if (m != 41) begin
            n_fail++;
            $display("FAIL abort_latency: done %0d cycles after second start, expected 41", m);
        end
        ref_sched(0, k2);
`else
        n_checks++;
        if (t != 41) begin
            n_fail++;
            $display("FAIL ignore_latency: done %0d cycles after first start, expected 41", t);
        end
        ref_sched(0, k1);
`endif
        bad = sched_bad(0);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL busy_start_sched: w[%0d]=%h, expected %h", bad, dut_word(0, bad), ref_w[bad]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [255:0] k;
        int n, bad;
        start_run(0, rand_key());
        repeat (19) begin @(posedge clk); #1; end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (dut_busy(0) !== 1'b0 || dut_done(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: busy/done %b/%b, expected 0/0", dut_busy(0), dut_done(0));
        end
        n_checks++;
        if (dut_zero(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_words: words nonzero, expected all zero");
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        k = rand_key();
        run_to_done(0, k, n);
        n_checks++;
        if (n != 41) begin
            n_fail++;
            $display("FAIL midreset_latency: done after %0d cycles, expected 41", n);
        end
        ref_sched(0, k);
        bad = sched_bad(0);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL midreset_sched: w[%0d]=%h, expected %h", bad, dut_word(0, bad), ref_w[bad]);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] k1, k2;
        int n, bad;
        k1 = rand_key();
        k2 = rand_key();
        run_to_done(1, k1, n);
        @(negedge clk);
        drive(1, k2, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (dut_done(1) !== 1'b1 || dut_busy(1) !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_flags: busy/done %b/%b, expected 0/1", dut_busy(1), dut_done(1));
        end
        ref_sched(1, k1);
        bad = sched_bad(1);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL hold_sched: w[%0d]=%h, expected %h", bad, dut_word(1, bad), ref_w[bad]);
        end
        start_run(1, k2);
        n_checks++;
        if (dut_done(1) !== 1'b0 || dut_busy(1) !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_flags: busy/done %b/%b, expected 1/0", dut_busy(1), dut_done(1));
        end
        n = 1;
        while (dut_done(1) !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (n != 47) begin
            n_fail++;
            $display("FAIL restart_latency: done after %0d cycles, expected 47", n);
        end
        ref_sched(1, k2);
        bad = sched_bad(1);
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL restart_sched: w[%0d]=%h, expected %h", bad, dut_word(1, bad), ref_w[bad]);
        end
    endtask

    // AES-128 encryption consuming the DUT round-key bus once done is high
    task automatic test_cipher_chain();
        logic [7:0]   s   [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [31:0]  wd;
        logic [127:0] pt, ct;
        int n;
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        run_to_done(0, KEY128, n);
        n_checks++;
        if (dut_done(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_enable: done %b, expected 1", dut_done(0));
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
                for (int c = 0; c < 4; c++)
                    for (int rr = 0; rr < 4; rr++) tmp[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
                for (int b = 0; b < 16; b++) s[b] = tmp[b];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int b = 0; b < 16; b++) begin
                wd   = dut_word(0, 4*r + b/4);
                s[b] = s[b] ^ wd[31 - 8*(b % 4) -: 8];
            end
        end
        for (int b = 0; b < 16; b++) ct[127 - 8*b -: 8] = s[b];
        n_checks++;
        if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin
            n_fail++;
            $display("FAIL chain_ciphertext: got %h, expected 3925841d02dc09fbdc118597196a0b32", ct);
        end
    endtask

    initial begin
        drive(0, 256'h0, 1'b0);
        drive(1, 256'h0, 1'b0);
        drive(2, 256'h0, 1'b0);
        build_sbox();
        test_reset();
        test_known_vectors();
        test_random_keys();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_cipher_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end
endmodule
